// File: rtl/crc_stream_pkg.sv
// crc_stream_pkg: shared state encoding, polynomial constants and CRC helper functions.
package crc_stream_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, RESULT} state_e;
  localparam logic [7:0]  CRC8_POLY   = 8'h07;
  localparam logic [15:0] CRC16_CCITT = 16'h1021;
  localparam logic [31:0] CRC32_POLY  = 32'h04C11DB7;
  function automatic logic [63:0] bitrev_f(input logic [63:0] v, input int w);
    bitrev_f = '0;
    for (int i = 0; i < w; i++) bitrev_f[w-1-i] = v[i];
  endfunction
  // bits[steps-1] is consumed first
  function automatic logic [63:0] crc_step_f(input logic [63:0] crc, input logic [63:0] bits,
                                             input logic [63:0] poly, input int p, input int steps);
    logic [63:0] c, m;
    logic fb;
    c = crc;
    m = (p == 64) ? '1 : ((64'd1 << p) - 64'd1);
    for (int i = 0; i < steps; i++) begin
      fb = c[p-1] ^ bits[steps-1-i];
      c  = ((c << 1) ^ (fb ? poly : 64'd0)) & m;
    end
    crc_step_f = c;
  endfunction
endpackage

// File: rtl/crc_stream_engine_step.sv
// crc_stream_step: combinational STEPS-bit unrolled serial CRC update.
import crc_stream_pkg::*;
module crc_stream_step #(
  parameter int          P     = 8,
  parameter logic [63:0] POLY  = 64'h07,
  parameter int          STEPS = 8
) (
  input  logic [P-1:0]     crc,
  input  logic [STEPS-1:0] bits,
  output logic [P-1:0]     nxt
);
  assign nxt = P'(crc_step_f(64'(crc), 64'(bits), POLY, P, STEPS));
endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming Rocksoft-style CRC over valid/ready beats, STEPS bits per cycle.
import crc_stream_pkg::*;
module crc_stream_engine #(
  parameter int          WORDWIDTH = 8,
  parameter int          POLYWIDTH = 8,
  parameter logic [63:0] POLY      = 64'(CRC8_POLY),
  parameter logic [63:0] INIT      = 64'h00,
  parameter bit          REFIN     = 1'b0,
  parameter bit          REFOUT    = 1'b0,
  parameter logic [63:0] XOROUT    = 64'h00,
  parameter logic [63:0] RESIDUE   = 64'h00,
  parameter int          STEPS     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WORDWIDTH-1:0] in_data_i,
  input  logic                 in_first_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [POLYWIDTH-1:0] out_crc_o,
  output logic                 out_match_o,
  output logic                 busy_o
);
  localparam int P  = POLYWIDTH;
  localparam int N  = WORDWIDTH / STEPS;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (STEPS < 1 || WORDWIDTH % STEPS != 0 || WORDWIDTH % 8 != 0 || P < 1 || P > 64 ||
      (POLY >> P) != 0 || (INIT >> P) != 0 || (XOROUT >> P) != 0 || (RESIDUE >> P) != 0) begin : g_bad
    $fatal(1, "crc_stream_engine: illegal parameter combination");
  end
  state_e               state_q, state_d;
  logic [P-1:0]         crc_q, crc_nxt, res, out_crc_q;
  logic [WORDWIDTH-1:0] beat_q, beat_in;
  logic [CW-1:0]        cnt_q;
  logic                 last_q, out_match_q, done;
  // reflect bytes up front so the shifter always consumes the beat MSB-first
  always_comb begin
    beat_in = '0;
    for (int b = 0; b < WORDWIDTH / 8; b++)
      for (int k = 0; k < 8; k++) beat_in[8*b+k] = REFIN ? in_data_i[8*b+7-k] : in_data_i[8*b+k];
  end
  crc_stream_step #(.P(P), .POLY(POLY), .STEPS(STEPS)) u_step (
    .crc(crc_q), .bits(beat_q[WORDWIDTH-1 -: STEPS]), .nxt(crc_nxt)
  );
  assign done        = cnt_q == CW'(N - 1);
  assign res         = (REFOUT ? P'(bitrev_f(64'(crc_nxt), P)) : crc_nxt) ^ XOROUT[P-1:0];
  assign in_ready_o  = state_q == IDLE;
  assign out_valid_o = state_q == RESULT;
  assign busy_o      = state_q != IDLE;
  assign out_crc_o   = out_crc_q;
  assign out_match_o = out_match_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid_i ? SHIFT : IDLE;
      SHIFT:   state_d = done ? (last_q ? RESULT : IDLE) : SHIFT;
      RESULT:  state_d = out_ready_i ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q       <= INIT[P-1:0];
      beat_q      <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      out_crc_q   <= '0;
      out_match_q <= 1'b0;
    end else if (state_q == IDLE && in_valid_i) begin
      beat_q <= beat_in;
      last_q <= in_last_i;
      cnt_q  <= '0;
      if (in_first_i) crc_q <= INIT[P-1:0];
    end else if (state_q == SHIFT) begin
      crc_q  <= crc_nxt;
      beat_q <= beat_q << STEPS;
      cnt_q  <= cnt_q + 1'b1;
      if (done && last_q) begin
        out_crc_q   <= res;
        out_match_q <= res == RESIDUE[P-1:0];
      end
    end
  end
endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: CRC-8 / CRC-32 byte engines plus a 32-bit 4-step engine against a bytewise model.
module tb_crc_stream_engine;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;

  logic       v_ab = 0, f_ab = 0, l_ab = 0, or_ab = 0;
  logic [7:0] d_ab = 0;
  logic       rdy_a, val_a, m_a, busy_a, rdy_b, val_b, m_b, busy_b;
  logic [7:0] crc_a;
  logic [31:0] crc_b;
  logic        v_c = 0, f_c = 0, l_c = 0, or_c = 0;
  logic [31:0] d_c = 0;
  logic        rdy_c, val_c, m_c, busy_c;
  logic [7:0]  crc_c;
  logic [63:0] ca, cb, cc;

  crc_stream_engine u_a (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v_ab), .in_ready_o(rdy_a), .in_data_i(d_ab),
    .in_first_i(f_ab), .in_last_i(l_ab), .out_valid_o(val_a), .out_ready_i(or_ab),
    .out_crc_o(crc_a), .out_match_o(m_a), .busy_o(busy_a));
  crc_stream_engine #(.POLYWIDTH(32), .POLY(64'h04C11DB7), .INIT(64'hFFFFFFFF), .REFIN(1'b1),
                      .REFOUT(1'b1), .XOROUT(64'hFFFFFFFF)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v_ab), .in_ready_o(rdy_b), .in_data_i(d_ab),
    .in_first_i(f_ab), .in_last_i(l_ab), .out_valid_o(val_b), .out_ready_i(or_ab),
    .out_crc_o(crc_b), .out_match_o(m_b), .busy_o(busy_b));
  crc_stream_engine #(.WORDWIDTH(32), .STEPS(4)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v_c), .in_ready_o(rdy_c), .in_data_i(d_c),
    .in_first_i(f_c), .in_last_i(l_c), .out_valid_o(val_c), .out_ready_i(or_c),
    .out_crc_o(crc_c), .out_match_o(m_c), .busy_o(busy_c));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // reference: one byte through the textbook serial CRC, honouring input reflection
  function automatic logic [63:0] m_byte(input logic [63:0] c, input logic [7:0] b, input int p,
                                         input logic [63:0] poly, input bit refin);
    logic [63:0] mask;
    logic bt, fb;
    mask = (p == 64) ? '1 : ((64'd1 << p) - 64'd1);
    for (int k = 0; k < 8; k++) begin
      bt = refin ? b[k] : b[7-k];
      fb = c[p-1] ^ bt;
      c = ((c << 1) ^ (fb ? poly : 64'd0)) & mask;
    end
    return c;
  endfunction
  function automatic logic [63:0] m_out(input logic [63:0] c, input int p, input bit refout,
                                        input logic [63:0] xo);
    logic [63:0] r;
    r = c;
    if (refout) begin
      r = '0;
      for (int i = 0; i < p; i++) if (c[i]) r = r | (64'd1 << (p - 1 - i));
    end
    return r ^ xo;
  endfunction

  task automatic send_ab(input logic [7:0] b, input bit f, input bit l);
    int t = 0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    v_ab = 1; d_ab = b; f_ab = f; l_ab = l;
    while (!rdy_a && t < 100) begin @(negedge clk); t++; end
    chk("ab_accept", {rdy_a, rdy_b}, 2'b11);
    @(negedge clk);
    v_ab = 0;
    ca = m_byte(f ? 64'h0 : ca, b, 8, 64'h07, 1'b0);
    cb = m_byte(f ? 64'hFFFFFFFF : cb, b, 32, 64'h04C11DB7, 1'b1);
  endtask

  task automatic get_ab(input int hold, output logic [7:0] oa, output logic ma,
                        output logic [31:0] ob, output logic mb);
    int t = 0;
    logic [39:0] s;
    while (!val_a && t < 100) begin @(negedge clk); t++; end
    chk("ab_out_valid", {val_a, val_b, rdy_a}, 3'b110);
    s = {crc_a, crc_b};
    repeat (hold) begin
      @(negedge clk);
      chk("ab_hold", {val_a, rdy_a, crc_a, crc_b}, {2'b10, s});
    end
    oa = crc_a; ma = m_a; ob = crc_b; mb = m_b;
    or_ab = 1;
    @(negedge clk);
    or_ab = 0;
    chk("ab_release", {val_a, val_b, rdy_a}, 3'b001);
  endtask

  task automatic send_c(input logic [31:0] w, input bit f, input bit l);
    int t = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    v_c = 1; d_c = w; f_c = f; l_c = l;
    while (!rdy_c && t < 100) begin @(negedge clk); t++; end
    chk("c_accept", rdy_c, 1);
    @(negedge clk);
    v_c = 0;
    if (f) cc = 0;
    for (int i = 3; i >= 0; i--) cc = m_byte(cc, w[8*i +: 8], 8, 64'h07, 1'b0);
  endtask

  task automatic get_c(input int hold, output logic [7:0] oc, output logic mc);
    int t = 0;
    logic [7:0] s;
    while (!val_c && t < 100) begin @(negedge clk); t++; end
    chk("c_out_valid", {val_c, rdy_c}, 2'b10);
    s = crc_c;
    repeat (hold) begin
      @(negedge clk);
      chk("c_hold", {val_c, rdy_c, crc_c}, {2'b10, s});
    end
    oc = crc_c; mc = m_c;
    or_c = 1;
    @(negedge clk);
    or_c = 0;
    chk("c_release", {val_c, rdy_c}, 2'b01);
  endtask

  typedef struct {
    int          len;
    logic [7:0]  b [10];
    logic [7:0]  e8;
    logic        e8m;
    logic [31:0] e32;
    bit          c32;
  } vec_t;
  vec_t tv [4];

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] oa, oc;
    logic [31:0] ob;
    logic ma, mb, mc;
    int cnt, len;
    logic [7:0] s8;
    logic [7:0] pat [9];
    pat = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    tv[0] = '{9,  '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h00}, 8'hF4, 1'b0, 32'hCBF43926, 1'b1};
    tv[1] = '{10, '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4}, 8'h00, 1'b1, 32'h0, 1'b0};
    tv[2] = '{1,  '{8'h61, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h20, 1'b0, 32'hE8B7BE43, 1'b1};
    tv[3] = '{1,  '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h89, 1'b0, 32'h0, 1'b0};
    ca = 64'h0; cb = 64'hFFFFFFFF; cc = 64'h0;
    repeat (2) @(negedge clk);
    chk("reset_a", {rdy_a, val_a, crc_a, m_a, busy_a}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    chk("reset_b", {rdy_b, val_b, crc_b, m_b, busy_b}, {1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
    chk("reset_c", {rdy_c, val_c, crc_c, m_c, busy_c}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    rst_n = 1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < tv[v].len; i++) send_ab(tv[v].b[i], i == 0, i == tv[v].len - 1);
      get_ab(v, oa, ma, ob, mb);
      chk($sformatf("vec%0d_crc8", v), oa, tv[v].e8);
      chk($sformatf("vec%0d_match8", v), ma, tv[v].e8m);
      if (tv[v].c32) chk($sformatf("vec%0d_crc32", v), ob, tv[v].e32);
    end

    // timing on the 32-bit, 4-step engine: non-last then last beat (concatenated)
    @(negedge clk);
    v_c = 1; d_c = 32'h31323334; f_c = 1; l_c = 0;
    chk("c_idle_ready", rdy_c, 1);
    @(negedge clk);
    v_c = 0;
    cc = 0;
    for (int i = 3; i >= 0; i--) cc = m_byte(cc, d_c[8*i +: 8], 8, 64'h07, 1'b0);
    cnt = 0;
    while (!rdy_c && cnt < 20) begin cnt++; @(negedge clk); end
    chk("c_ready_low_cycles", cnt, 8);
    v_c = 1; d_c = 32'h35363738; f_c = 0; l_c = 1;
    @(negedge clk);
    v_c = 0;
    for (int i = 3; i >= 0; i--) cc = m_byte(cc, d_c[8*i +: 8], 8, 64'h07, 1'b0);
    cnt = 1;
    while (!val_c && cnt < 20) begin @(negedge clk); cnt++; end
    chk("c_valid_latency", cnt, 9);
    s8 = crc_c;
    v_c = 1; d_c = 32'hDEADBEEF; f_c = 1; l_c = 1;
    repeat (5) begin
      @(negedge clk);
      chk("c_stall", {val_c, rdy_c, crc_c}, {2'b10, s8});
    end
    chk("c_timing_crc", crc_c, m_out(cc, 8, 1'b0, 64'h0));
    v_c = 0; or_c = 1;
    @(negedge clk);
    or_c = 0;
    chk("c_after_handshake", {val_c, rdy_c, busy_c}, 3'b010);

    for (int fr = 0; fr < 30; fr++) begin
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++)
        send_ab(8'($urandom), (i == 0 && $urandom_range(0, 3) != 0) || $urandom_range(0, 7) == 0, i == len - 1);
      get_ab($urandom_range(0, 3), oa, ma, ob, mb);
      chk("rand_crc8", oa, m_out(ca, 8, 1'b0, 64'h0));
      chk("rand_match8", ma, m_out(ca, 8, 1'b0, 64'h0) == 64'h0);
      chk("rand_crc32", ob, m_out(cb, 32, 1'b1, 64'hFFFFFFFF));
      chk("rand_match32", mb, m_out(cb, 32, 1'b1, 64'hFFFFFFFF) == 64'h0);
    end
    for (int fr = 0; fr < 15; fr++) begin
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++)
        send_c($urandom, (i == 0 && $urandom_range(0, 3) != 0) || $urandom_range(0, 7) == 0, i == len - 1);
      get_c($urandom_range(0, 3), oc, mc);
      chk("rand_c_crc", oc, m_out(cc, 8, 1'b0, 64'h0));
      chk("rand_c_match", mc, m_out(cc, 8, 1'b0, 64'h0) == 64'h0);
    end

    // reset pulsed while beat 2 of the frame is shifting
    send_ab(8'h31, 1'b1, 1'b0);
    @(negedge clk);
    v_ab = 1; d_ab = 8'h32; f_ab = 0; l_ab = 0;
    chk("mid_ready", rdy_a, 1);
    @(negedge clk);
    v_ab = 0;
    chk("mid_shifting", {busy_a, rdy_a}, 2'b10);
    rst_n = 0;
    #1;
    chk("mid_reset_a", {rdy_a, val_a, busy_a, crc_a, m_a}, {3'b100, 8'h00, 1'b0});
    chk("mid_reset_b", {rdy_b, val_b, busy_b, crc_b}, {3'b100, 32'h0});
    @(negedge clk);
    rst_n = 1;
    ca = 64'h0; cb = 64'hFFFFFFFF; cc = 64'h0;
    repeat (3) begin
      @(negedge clk);
      chk("no_spurious_valid", {val_a, val_b, busy_a}, 3'b000);
    end
    for (int i = 0; i < 9; i++) begin
      chk("resend_no_valid", val_a, 0);
      send_ab(pat[i], i == 0, i == 8);
    end
    get_ab(1, oa, ma, ob, mb);
    chk("resend_crc8", oa, 8'hF4);
    chk("resend_crc32", ob, 32'hCBF43926);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
